// File: rtl/sobel_edge_if.sv
// Window-in / gradient-out bundle between the 3x3 matrix generator, sobel_edge and the frame writer.
interface sobel_edge_if;
  logic       matrix_vs;
  logic       matrix_de;
  logic [7:0] matrix_p11, matrix_p12, matrix_p13;
  logic [7:0] matrix_p21, matrix_p22, matrix_p23;
  logic [7:0] matrix_p31, matrix_p32, matrix_p33;
  logic [7:0] threshold;
  logic       post_vs;
  logic       post_de;
  logic [7:0] post_data;

  modport master (
    output matrix_vs, matrix_de,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33,
    output threshold,
    input  post_vs, post_de, post_data
  );

  modport slave (
    input  matrix_vs, matrix_de,
    input  matrix_p11, matrix_p12, matrix_p13,
    input  matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33,
    input  threshold,
    output post_vs, post_de, post_data
  );
endinterface

// File: rtl/sobel_edge.sv
// 4-stage Sobel gradient on a 3x3 window stream, border rows/cols forced to zero.
// Define SOBEL_BINARY_EN to output a thresholded (00/FF) edge map instead of the saturated magnitude.
module sobel_edge #(
  parameter logic [11:0] IMG_HDISP = 12'd1280,
  parameter logic [11:0] IMG_VDISP = 12'd720
) (
  input logic         clk,
  input logic         rst,
  sobel_edge_if.slave bus
);
  localparam int STAGES = 4;

  logic [STAGES:1] de_pipe, vs_pipe;
  logic [11:0]     col, row;
  logic            de_fall, vs_rise;

  // timing side-band
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_pipe <= '0;
      vs_pipe <= '0;
    end else begin
      de_pipe <= {de_pipe[STAGES-1:1], bus.matrix_de};
      vs_pipe <= {vs_pipe[STAGES-1:1], bus.matrix_vs};
    end
  end

  // stage 1 of the side-band doubles as the edge-detect copy of the inputs
  assign de_fall = de_pipe[1] & ~bus.matrix_de;
  assign vs_rise = bus.matrix_vs & ~vs_pipe[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      col <= '0;
    else if (bus.matrix_de)
      col <= (col < IMG_HDISP) ? col + 12'd1 : col;
    else if (de_fall)
      col <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      row <= '0;
    else if (vs_rise)
      row <= '0;
    else if (de_fall && row < IMG_VDISP)
      row <= row + 12'd1;
  end

  // S1: weighted column/row sums
  logic [9:0] gx_p_c, gx_n_c, gy_p_c, gy_n_c;
  logic [9:0] gx_p, gx_n, gy_p, gy_n;
  logic       mask1;

  assign gx_p_c = {2'b0, bus.matrix_p13} + {1'b0, bus.matrix_p23, 1'b0} + {2'b0, bus.matrix_p33};
  assign gx_n_c = {2'b0, bus.matrix_p11} + {1'b0, bus.matrix_p21, 1'b0} + {2'b0, bus.matrix_p31};
  assign gy_p_c = {2'b0, bus.matrix_p31} + {1'b0, bus.matrix_p32, 1'b0} + {2'b0, bus.matrix_p33};
  assign gy_n_c = {2'b0, bus.matrix_p11} + {1'b0, bus.matrix_p12, 1'b0} + {2'b0, bus.matrix_p13};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx_p  <= '0;
      gx_n  <= '0;
      gy_p  <= '0;
      gy_n  <= '0;
      mask1 <= 1'b0;
    end else begin
      gx_p  <= gx_p_c;
      gx_n  <= gx_n_c;
      gy_p  <= gy_p_c;
      gy_n  <= gy_n_c;
      mask1 <= (col < 12'd2) | (row < 12'd2);
    end
  end

  // S2: absolute differences
  logic [9:0] gx, gy;
  logic       mask2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx    <= '0;
      gy    <= '0;
      mask2 <= 1'b0;
    end else begin
      gx    <= (gx_p >= gx_n) ? gx_p - gx_n : gx_n - gx_p;
      gy    <= (gy_p >= gy_n) ? gy_p - gy_n : gy_n - gy_p;
      mask2 <= mask1;
    end
  end

  // S3: L1 magnitude
  logic [10:0] mag;
  logic        mask3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag   <= '0;
      mask3 <= 1'b0;
    end else begin
      mag   <= {1'b0, gx} + {1'b0, gy};
      mask3 <= mask2;
    end
  end

  logic [7:0] result;

`ifdef SOBEL_BINARY_EN
  // threshold rides with its window so a mid-line change hits exactly that pixel
  logic [7:0] thr1, thr2, thr3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr1 <= '0;
      thr2 <= '0;
      thr3 <= '0;
    end else begin
      thr1 <= bus.threshold;
      thr2 <= thr1;
      thr3 <= thr2;
    end
  end

  assign result = (mag >= {3'b0, thr3}) ? 8'hFF : 8'h00;
`else
  logic unused_threshold;

  assign unused_threshold = &{1'b0, bus.threshold};
  assign result = (mag > 11'd255) ? 8'hFF : mag[7:0];
`endif

  // S4: output register
  logic [7:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data_q <= '0;
    else
      data_q <= (de_pipe[3] && !mask3) ? result : 8'h00;
  end

  assign bus.post_data = data_q;
  assign bus.post_de   = de_pipe[STAGES];
  assign bus.post_vs   = vs_pipe[STAGES];
endmodule

// File: tb/tb_sobel_edge.sv
// Scoreboard bench for sobel_edge: stimulus pushes per-cycle expectations, a negedge monitor pops them 4 cycles later.
module tb_sobel_edge;
  localparam int K_FLAT = 0, K_STEP = 1, K_SAT = 2, K_M98 = 3, K_M100 = 4, K_RAND = 5;
`ifdef SOBEL_BINARY_EN
  localparam bit BIN = 1'b1;
`else
  localparam bit BIN = 1'b0;
`endif

  typedef logic [8:0][7:0] win_t;  // [0]=p11 [1]=p12 [2]=p13 [3]=p21 .. [8]=p33
  typedef struct {
    int         stamp;
    logic       vs;
    logic       de;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc_cnt = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  sobel_edge_if vif();
  sobel_edge dut (.clk(clk), .rst(rst), .bus(vif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int ref_mag(input win_t w);
    int gx, gy;
    gx = (int'(w[2]) + 2 * int'(w[5]) + int'(w[8])) - (int'(w[0]) + 2 * int'(w[3]) + int'(w[6]));
    gy = (int'(w[6]) + 2 * int'(w[7]) + int'(w[8])) - (int'(w[0]) + 2 * int'(w[1]) + int'(w[2]));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return gx + gy;
  endfunction

  function automatic win_t mk_win(input int kind);
    win_t w = '0;
    case (kind)
      K_FLAT: for (int i = 0; i < 9; i++) w[i] = 8'h80;
      K_STEP: begin
        for (int i = 0; i < 9; i++) w[i] = 8'd10;
        w[0] = 8'd0; w[3] = 8'd0; w[6] = 8'd0;
      end
      K_SAT:  begin w[2] = 8'd255; w[5] = 8'd255; w[8] = 8'd255; end
      K_M98:  w[5] = 8'd49;
      K_M100: w[5] = 8'd50;
      default: for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
    endcase
    return w;
  endfunction

  // hand-derived magnitudes for the directed windows, reference model only for random ones
  function automatic logic [7:0] exp_of(input int kind, input win_t w, input logic [7:0] thr);
    int mag;
    case (kind)
      K_FLAT:  mag = 0;
      K_STEP:  mag = 40;
      K_SAT:   mag = 1020;
      K_M98:   mag = 98;
      K_M100:  mag = 100;
      default: mag = ref_mag(w);
    endcase
    if (BIN) return (mag >= int'(thr)) ? 8'hFF : 8'h00;
    return (mag > 255) ? 8'hFF : 8'(mag);
  endfunction

  task automatic cyc(input logic vs, input logic de, input win_t w, input logic [7:0] thr,
                     input logic [7:0] e);
    exp_t x;
    vif.matrix_vs  = vs;
    vif.matrix_de  = de;
    vif.matrix_p11 = w[0]; vif.matrix_p12 = w[1]; vif.matrix_p13 = w[2];
    vif.matrix_p21 = w[3]; vif.matrix_p22 = w[4]; vif.matrix_p23 = w[5];
    vif.matrix_p31 = w[6]; vif.matrix_p32 = w[7]; vif.matrix_p33 = w[8];
    vif.threshold  = thr;
    x.stamp = cyc_cnt;
    x.vs    = vs;
    x.de    = de;
    x.data  = de ? e : 8'd0;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic vs, input int n);
    for (int i = 0; i < n; i++) cyc(vs, 1'b0, '0, 8'd100, 8'd0);
  endtask

  task automatic pix(input int r, input int c, input int kind, input logic [7:0] thr);
    win_t       w;
    logic [7:0] e;
    w = mk_win(kind);
    e = (r < 2 || c < 2) ? 8'd0 : exp_of(kind, w, thr);
    cyc(1'b1, 1'b1, w, thr, e);
  endtask

  task automatic line(input int r, input int n, input int kind);
    for (int c = 0; c < n; c++) pix(r, c, kind, 8'd100);
    idle(1'b1, 2);
  endtask

  task automatic frame_start(input int lo);
    idle(1'b0, lo);
    idle(1'b1, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].stamp + 4 < cyc_cnt) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL slot_skipped: stamp %0d never compared, now cycle %0d", e.stamp, cyc_cnt);
      end
      if (sb.size() > 0 && sb[0].stamp + 4 == cyc_cnt) begin
        e = sb.pop_front();
        chk($sformatf("post_vs@%0d", e.stamp), vif.post_vs, e.vs);
        chk($sformatf("post_de@%0d", e.stamp), vif.post_de, e.de);
        chk($sformatf("post_data@%0d", e.stamp), vif.post_data, e.data);
      end
    end
  end

  initial begin
    vif.matrix_vs = 1'b0; vif.matrix_de = 1'b0; vif.threshold = 8'd100;
    vif.matrix_p11 = '0; vif.matrix_p12 = '0; vif.matrix_p13 = '0;
    vif.matrix_p21 = '0; vif.matrix_p22 = '0; vif.matrix_p23 = '0;
    vif.matrix_p31 = '0; vif.matrix_p32 = '0; vif.matrix_p33 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_post_vs", vif.post_vs, 0);
    chk("reset_post_de", vif.post_de, 0);
    chk("reset_post_data", vif.post_data, 0);
    rst = 1'b0;

    // uniform 8x4 frame: zero gradient everywhere
    frame_start(2);
    for (int r = 0; r < 4; r++) line(r, 8, K_FLAT);

    // vertical step and saturation, entered through a one-cycle vs low gap
    frame_start(1);
    line(0, 5, K_RAND);
    line(1, 5, K_RAND);
    pix(2, 0, K_RAND, 8'd100);
    pix(2, 1, K_RAND, 8'd100);
    pix(2, 2, K_STEP, 8'd100);
    pix(2, 3, K_STEP, 8'd100);
    pix(2, 4, K_SAT, 8'd100);
    idle(1'b1, 2);

    // 6x5 random frame: border rows/cols must be zero
    frame_start(2);
    for (int r = 0; r < 5; r++) line(r, 6, K_RAND);

    // threshold boundaries, threshold changed per window
    frame_start(2);
    line(0, 4, K_FLAT);
    line(1, 4, K_FLAT);
    pix(2, 0, K_RAND, 8'd100);
    pix(2, 1, K_RAND, 8'd100);
    pix(2, 2, K_M98, 8'd100);
    pix(2, 3, K_M100, 8'd100);
    pix(2, 4, K_M100, 8'd101);
    pix(2, 5, K_SAT, 8'd100);
    pix(2, 6, K_M98, 8'd98);
    idle(1'b1, 2);

    // de gap inside a line restarts col and counts as a line end
    frame_start(2);
    line(0, 4, K_SAT);
    line(1, 4, K_SAT);
    for (int c = 0; c < 3; c++) pix(2, c, K_SAT, 8'd100);
    idle(1'b1, 1);
    for (int c = 0; c < 3; c++) pix(3, c, K_SAT, 8'd100);
    idle(1'b1, 2);
    line(4, 4, K_SAT);

    // reset in the middle of row 3 with a nonzero result in flight
    frame_start(2);
    line(0, 4, K_SAT);
    line(1, 4, K_SAT);
    line(2, 4, K_SAT);
    for (int c = 0; c < 6; c++) pix(3, c, K_SAT, 8'd100);
    rst = 1'b1;
    vif.matrix_de = 1'b0;
    #1;
    chk("rst_async_post_vs", vif.post_vs, 0);
    chk("rst_async_post_de", vif.post_de, 0);
    chk("rst_async_post_data", vif.post_data, 0);
    sb.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_hold_post_de", vif.post_de, 0);
      chk("rst_hold_post_data", vif.post_data, 0);
    end
    rst = 1'b0;
    idle(1'b1, 2);
    line(0, 4, K_SAT);
    line(1, 4, K_SAT);
    frame_start(2);
    line(0, 4, K_SAT);
    line(1, 4, K_SAT);
    line(2, 4, K_SAT);

    idle(1'b0, 6);
    repeat (20) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
